behavior_decode_stream: RTL and testbench
=========================================

BEHAVIOR_DECODE_STREAM -- requirements
Module: behavior_decode_stream

Interface
REQ-001 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-003 Port in_data, input, 4: encoded nibble produced by the behaviour-compare encoder.
REQ-004 Port in_valid, input, 1: in_data valid this cycle.
REQ-005 Port in_ready, output, 1: block can accept a nibble this cycle.
REQ-006 Port out_data, output, 4: decoded nibble.
REQ-007 Port out_amb, output, 1: out_data came from an ambiguous code.
REQ-008 Port out_err, output, 1: out_data came from a code the encoder never produces.
REQ-009 Port out_valid, output, 1: out_* hold a valid entry.
REQ-010 Port out_ready, input, 1: consumer accepts the entry this cycle.
REQ-011 Port stats_clr, input, 1: synchronous clear of statistics counters.
REQ-012 Port amb_cnt, output, 8: count of accepted ambiguous codes.
REQ-013 Port err_cnt, output, 8: count of accepted invalid codes.

Function
REQ-014 The decode map SHALL be: codes 1..4 -> code-1; codes 5,6 -> code-1 with amb=1; codes 7..9 -> code+1; codes 11..15 -> code; codes 0,10 -> 0 with err=1.
REQ-015 Input transfer SHALL occur when in_valid and in_ready are both high; output transfer SHALL occur when out_valid and out_ready are both high.
REQ-016 Decoded entries SHALL be held in a 2-entry FIFO with occupancy 0..2 and in-order delivery.
REQ-017 in_ready SHALL be high exactly when occupancy < 2; in_ready SHALL NOT depend combinationally on out_ready.
REQ-018 out_valid SHALL be high exactly when occupancy > 0; out_data/out_amb/out_err SHALL present the head entry.
REQ-019 A nibble accepted in cycle N SHALL appear on the outputs in cycle N+1 when the FIFO was empty.
REQ-020 Push and pop in the same cycle at occupancy 1 SHALL leave occupancy at 1 with the new entry at the head in the next cycle.
REQ-021 While out_valid is high and out_ready is low, the out_* values SHALL remain stable.
REQ-022 Each accepted code SHALL increment amb_cnt when ambiguous and err_cnt when invalid; both counters SHALL saturate at 255.
REQ-023 stats_clr SHALL zero both counters in the next cycle and take priority over a simultaneous increment.

Reset
REQ-024 When rst_n is low at a clock edge, the block SHALL set occupancy to 0, out_valid to 0, in_ready to 1 in the following cycle, out_data/out_amb/out_err to 0, and amb_cnt/err_cnt to 0.
REQ-025 Reset during a transfer SHALL discard all buffered entries; no partial entry SHALL survive.

Configuration
REQ-026 Macro BEHAVIOR_DECODE_STATS_EN: when defined, the counters in REQ-022/023 SHALL be implemented.
REQ-027 When BEHAVIOR_DECODE_STATS_EN is undefined, amb_cnt and err_cnt SHALL be tied to 0, stats_clr SHALL be ignored, and no counter flops SHALL exist; all other behaviour SHALL be unchanged.

Structure
REQ-028 A shared package SHALL hold the nibble width (4), the FIFO depth (2), the counter width (8), and the constants INV_CODE_A=0, INV_CODE_B=10, AMB_LO=5, AMB_HI=6.
REQ-029 The combinational map SHALL live in the sub-module behavior_decode_lut (in 4b, out data 4b, amb, err); behavior_decode_stream SHALL instantiate it once on the input side.

Verification
REQ-030 After reset, hold out_ready=1 and send codes 0..15 back-to-back -> outputs 0,0,1,2,3,4,5,8,9,10,0,11,12,13,14,15, one per cycle starting one cycle after the first accept; amb on codes 5,6; err on codes 0,10.
REQ-031 Hold out_ready=0 and offer codes 3,7,9 -> codes 3 and 7 are accepted, in_ready drops, and 9 is held; out_data=2 stays stable; then raise out_ready -> outputs 2,8,10 in order.
REQ-032 With BEHAVIOR_DECODE_STATS_EN defined, accept 300 copies of code 5 -> amb_cnt=255 and err_cnt=0; pulse stats_clr while code 10 is being accepted -> both counters read 0 in the next cycle.
REQ-033 Fill the FIFO to 2 entries, then drive rst_n=0 for one cycle -> out_valid=0, in_ready=1, and counters=0 in the next cycle; entries accepted afterwards decode normally.
REQ-034 At occupancy 1, apply a simultaneous push of code 12 and a pop -> occupancy stays 1 and out_data=12 in the next cycle.

Source files
------------

// File: rtl/behavior_decode_stream_pkg.sv
// ---------------------------------------------------------------------------
// behavior_decode_stream_pkg
// Shared widths, depths and code constants for the behaviour-compare decode
// stream. Imported by behavior_decode_lut and behavior_decode_stream.
// ---------------------------------------------------------------------------
package behavior_decode_stream_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 8;

  // Pointer and occupancy widths for the 2-entry buffer.
  localparam int PTR_W = 1;
  localparam int OCC_W = 2;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Codes the encoder never produces.
  localparam logic [NIBBLE_W-1:0] INV_CODE_A = 4'd0;
  localparam logic [NIBBLE_W-1:0] INV_CODE_B = 4'd10;

  // Range of codes that map to more than one original nibble.
  localparam logic [NIBBLE_W-1:0] AMB_LO = 4'd5;
  localparam logic [NIBBLE_W-1:0] AMB_HI = 4'd6;

  // One decoded FIFO entry.
  typedef struct packed {
    logic [NIBBLE_W-1:0] data;
    logic                amb;
    logic                err;
  } dec_entry_t;

endpackage

// File: rtl/behavior_decode_lut.sv
// ---------------------------------------------------------------------------
// behavior_decode_lut
// Purely combinational decode of one encoded nibble.
//   code : encoded nibble
//   data : decoded nibble (0 for invalid codes)
//   amb  : code maps ambiguously (codes 5,6)
//   err  : code is never produced by the encoder (codes 0,10)
// Map: 1..4 -> code-1, 5..6 -> code-1 (amb), 7..9 -> code+1,
//      11..15 -> code, 0/10 -> 0 (err).
// ---------------------------------------------------------------------------
module behavior_decode_lut
  import behavior_decode_stream_pkg::*;
(
  input  logic [NIBBLE_W-1:0] code,
  output logic [NIBBLE_W-1:0] data,
  output logic                amb,
  output logic                err
);

  always_comb begin
    data = '0;
    amb  = 1'b0;
    err  = 1'b0;
    if (code == INV_CODE_A || code == INV_CODE_B) begin
      err = 1'b1;
    end else if (code >= AMB_LO && code <= AMB_HI) begin
      data = code - 4'd1;
      amb  = 1'b1;
    end else if (code <= 4'd4) begin
      // code 0 already excluded above, so this is 1..4
      data = code - 4'd1;
    end else if (code <= 4'd9) begin
      data = code + 4'd1;
    end else begin
      data = code;
    end
  end

endmodule

// File: rtl/behavior_decode_stream.sv
// ---------------------------------------------------------------------------
// behavior_decode_stream
// Decodes a stream of encoded nibbles through behavior_decode_lut into a
// 2-entry in-order FIFO, with optional ambiguous/invalid statistics.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_data/in_valid    : encoded nibble input, in_ready = space available
//   out_data/amb/err    : head FIFO entry, out_valid = FIFO non-empty,
//                         out_ready = consumer takes the head this cycle
//   stats_clr           : synchronous clear of amb_cnt/err_cnt
//   amb_cnt, err_cnt    : saturating counts of accepted amb/err codes
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and in_ready is a function of the
// registered occupancy only (no combinational path from out_ready).
//
// Configuration macro BEHAVIOR_DECODE_STATS_EN: when defined the statistics
// counters exist; otherwise amb_cnt/err_cnt are constant 0 and stats_clr is
// ignored.
// ---------------------------------------------------------------------------
module behavior_decode_stream
  import behavior_decode_stream_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NIBBLE_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NIBBLE_W-1:0] out_data,
  output logic                out_amb,
  output logic                out_err,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                stats_clr,
  output logic [CNT_W-1:0]    amb_cnt,
  output logic [CNT_W-1:0]    err_cnt
);

  dec_entry_t        lut_entry;
  dec_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [OCC_W-1:0]  occ;
  logic              push;
  logic              pop;

  // Decode on the input side so the FIFO stores finished entries.
  behavior_decode_lut u_lut (
    .code (in_data),
    .data (lut_entry.data),
    .amb  (lut_entry.amb),
    .err  (lut_entry.err)
  );

  assign in_ready  = (occ < OCC_FULL);
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data  = mem[rd_ptr].data;
  assign out_amb   = mem[rd_ptr].amb;
  assign out_err   = mem[rd_ptr].err;

  // Storage is cleared on reset so the idle head reads as all zeros.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= lut_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef BEHAVIOR_DECODE_STATS_EN
  logic [CNT_W-1:0] amb_q;
  logic [CNT_W-1:0] err_q;

  // Clear wins over a same-cycle increment; counts stick at CNT_MAX.
  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr) begin
      amb_q <= '0;
      err_q <= '0;
    end else begin
      if (push && lut_entry.amb && amb_q != CNT_MAX) begin
        amb_q <= amb_q + CNT_W'(1);
      end
      if (push && lut_entry.err && err_q != CNT_MAX) begin
        err_q <= err_q + CNT_W'(1);
      end
    end
  end

  assign amb_cnt = amb_q;
  assign err_cnt = err_q;
`else
  logic unused_stats_clr;

  assign unused_stats_clr = stats_clr;
  assign amb_cnt          = '0;
  assign err_cnt          = '0;
`endif

endmodule

// File: tb/tb_behavior_decode_stream.sv
// ---------------------------------------------------------------------------
// tb_behavior_decode_stream
// Self-checking bench for behavior_decode_stream: directed phases plus a
// random phase, with an expected-value queue filled at input transfers and
// drained at output transfers.
// ---------------------------------------------------------------------------
module tb_behavior_decode_stream;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_amb;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;
  logic       stats_clr;
  logic [7:0] amb_cnt;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  // {data, amb, err}
  logic [5:0] exp_q[$];
  logic       hold_pending;
  logic [5:0] hold_val;

  // Expected decoded value per code 0..15.
  logic [3:0] exp_tab [16] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8,
                               4'd9, 4'd10, 4'd0, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

  behavior_decode_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_amb   (out_amb),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .stats_clr (stats_clr),
    .amb_cnt   (amb_cnt),
    .err_cnt   (err_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] model(input logic [3:0] c);
    logic amb;
    logic err;
    amb = (c == 4'd5) || (c == 4'd6);
    err = (c == 4'd0) || (c == 4'd10);
    return {exp_tab[c], amb, err};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      step();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  // Sampled on the falling edge: values here are what the next rising edge sees.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_pending <= 1'b0;
    end else begin
      if (hold_pending) begin
        chk("hold_stable", {out_data, out_amb, out_err}, hold_val);
      end
      hold_pending <= out_valid && !out_ready;
      hold_val     <= {out_data, out_amb, out_err};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("sb_extra_out", exp_q.size(), 1);
        else                   chk("sb_out", {out_data, out_amb, out_err}, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b0;
    stats_clr = 1'b0;
    hold_pending = 1'b0;
    hold_val     = '0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", {out_data, out_amb, out_err}, 0);
    chk("rst_amb_cnt", amb_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);

    // All 16 codes back-to-back with the consumer always ready
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      in_valid = 1'b1;
      in_data  = 4'(c);
      step();
      chk("stream_in_ready", in_ready, 1);
      if (c == 0) begin
        chk("first_latency_valid", out_valid, 1);
        chk("first_latency_data", {out_data, out_amb, out_err}, 6'b0000_01);
      end
    end
    drain("drain_stream");

    // Backpressure: 3 and 7 accepted, 9 held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'd3;
    step();
    in_data = 4'd7;
    step();
    in_data = 4'd9;
    for (int k = 0; k < 3; k++) begin
      chk("full_in_ready", in_ready, 0);
      chk("full_out_data", out_data, 2);
      step();
    end
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 10) begin
      step();
      n++;
    end
    chk("held_accept_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    drain("drain_backpressure");

    // Simultaneous push and pop at occupancy 1
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'd4;
    step();
    in_valid = 1'b0;
    chk("occ1_head", out_data, 3);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'd12;
    step();
    in_valid = 1'b0;
    chk("pushpop_data", out_data, 12);
    chk("pushpop_valid", out_valid, 1);
    chk("pushpop_in_ready", in_ready, 1);
    step();
    chk("pushpop_empty", out_valid, 0);
    drain("drain_pushpop");

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain("drain_random");

`ifdef BEHAVIOR_DECODE_STATS_EN
    // Saturation and clear priority
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("clr_amb", amb_cnt, 0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'd5;
    for (int k = 0; k < 300; k++) begin
      step();
    end
    in_valid = 1'b0;
    chk("sat_amb_cnt", amb_cnt, 255);
    chk("sat_err_cnt", err_cnt, 0);
    in_valid  = 1'b1;
    in_data   = 4'd10;
    stats_clr = 1'b1;
    step();
    in_valid  = 1'b0;
    stats_clr = 1'b0;
    chk("clrprio_amb_cnt", amb_cnt, 0);
    chk("clrprio_err_cnt", err_cnt, 0);
    in_valid = 1'b1;
    in_data  = 4'd10;
    step();
    in_valid = 1'b0;
    chk("err_inc", err_cnt, 1);
    drain("drain_stats");
`else
    // Counters stay at zero even after amb/err traffic and a clear pulse
    chk("nostats_amb_cnt", amb_cnt, 0);
    chk("nostats_err_cnt", err_cnt, 0);
    stats_clr = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'd0;
    step();
    stats_clr = 1'b0;
    in_valid  = 1'b0;
    chk("nostats_err_after", err_cnt, 0);
    drain("drain_nostats");
`endif

    // Reset while full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'd11;
    step();
    in_data = 4'd13;
    step();
    in_valid = 1'b0;
    chk("prefill_full", in_ready, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_out_data", {out_data, out_amb, out_err}, 0);
    chk("flush_amb_cnt", amb_cnt, 0);
    chk("flush_err_cnt", err_cnt, 0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'd8;
    step();
    in_valid = 1'b0;
    chk("post_flush_data", out_data, 9);
    drain("drain_post_flush");

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
